// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = ai - bi - bin, with borrow out.
module full_subtractor (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = ai ^ bi ^ bin;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, one bit per cycle LSB first, with a done pulse after WIDTH cycles.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic             borrow_q;

  logic             d;
  logic             bout;

  // Control: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = (cnt == LAST);
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  full_subtractor u_cell (
    .ai   (a_sr[0]),
    .bi   (b_sr[0]),
    .bin  (br),
    .d    (d),
    .bout (bout)
  );

  // Operand shift registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    if (load) begin
      a_sr <= a;
      b_sr <= b;
    end else if (step) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
    end
  end

  // Bit stage: borrow chain, counter, result shift and final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      br       <= 1'b0;
      res      <= '0;
      borrow_q <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      br  <= 1'b0;
    end else if (step) begin
      br  <= bout;
      res <= {d, res[WIDTH-1:1]};
      if (last) begin
        borrow_q <= bout;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign diff   = res;
  assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  // On the last bit the shift registers present the operand sign bits
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (step && last) begin
      ovf_q <= signed_ovf(a_sr[0], b_sr[0], d);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction a - b.
REQ-005 SHALL have port: a  input  WIDTH  minuend, sampled only on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, sampled only on the accepting edge.
REQ-007 SHALL have port: busy  output  1  high while state is RUN.
REQ-008 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-009 SHALL have port: diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-010 SHALL have port: borrow  output  1  final borrow-out, 1 iff a < b unsigned.
REQ-011 SHALL have port: ovf  output  1  signed overflow flag, present only with SERIAL_SUB_OVF_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after WIDTH bit cycles, DONE->IDLE unconditionally.
REQ-013 SHALL, on the accepting edge (IDLE and start=1), load a and b into shift registers, clear the borrow flip-flop and clear the bit counter.
REQ-014 SHALL, per RUN cycle, process one bit LSB first: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-015 SHALL shift each d into the result register so that after WIDTH RUN cycles diff holds the full LSB-aligned result.
REQ-016 SHALL assert done for exactly one cycle, in the cycle after the last RUN edge; latency = WIDTH+1 edges from the accepting edge to done high.
REQ-017 SHALL hold diff, borrow and ovf stable from done until the next accepting edge.
REQ-018 SHALL ignore start while in RUN or DONE; no restart, no operand resampling.
REQ-019 SHALL accept start in the cycle after done (back-to-back operation, period WIDTH+2).
REQ-020 SHALL keep a, b changes after the accepting edge from affecting the result.
REQ-021 SHALL size the bit counter as $clog2(WIDTH) bits with no wrap past WIDTH-1.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, force state IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, counter=0.
REQ-023 SHALL abort any in-flight operation on reset mid-RUN; no done pulse for the aborted operation.
REQ-024 SHALL give rst priority over start in the same cycle.

Configuration
REQ-025 SHALL, with SERIAL_SUB_OVF_EN defined, drive ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), registered with diff.
REQ-026 SHALL, without SERIAL_SUB_OVF_EN, omit the ovf port and its logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place the state enum typedef (IDLE, RUN, DONE) in shared package serial_sub_pkg.
REQ-028 SHALL instantiate one combinational bit cell, sub-module full_subtractor (ai, bi, bin -> d, bout).

Verification
REQ-029 SHALL cover (WIDTH=8): a=0x05, b=0x03, start -> done 9 edges later, diff=0x02, borrow=0, ovf=0.
REQ-030 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, borrow=1, ovf=0.
REQ-031 SHALL cover: a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1 (macro on); ovf port absent (macro off).
REQ-032 SHALL cover: start re-pulsed with a=0xFF mid-RUN -> ignored, original result returned, single done.
REQ-033 SHALL cover: rst at RUN cycle 4 -> all outputs 0, no done; new start afterwards yields correct result.
REQ-034 SHALL cover: exhaustive WIDTH=2 loop over all 16 {a,b} pairs back-to-back -> each diff/borrow matches the reference model.
